// File: rtl/rename_alloc_pkg.sv
// Shared rename sizing: slots per architectural register and slot index width.
// Tag layout is {arch_reg[4:0], slot[RB-1:0]}.
package rename_alloc_pkg;
    localparam int RP = 4;
    localparam int RB = 2;
    localparam int TW = 5 + RB;
endpackage

// File: rtl/rename_alloc_free_pick.sv
// Find-first-zero over one register's slot-in-use bits.
// Lowest free slot wins.
module rn_free_pick
    import rename_alloc_pkg::*;
(
    input  logic [RP-1:0] used,
    output logic          any_free,
    output logic [RB-1:0] idx
);
    always_comb begin
        any_free = 1'b0;
        idx      = '0;
        for (int i = RP - 1; i >= 0; i--) begin
            if (!used[i]) begin
                any_free = 1'b1;
                idx      = RB'(i);
            end
        end
    end
endmodule

// File: rtl/rename_alloc.sv
// Single-issue rename stage: source tag lookup, rd slot allocation,
// one registered output stage toward issue.
module rename_alloc
    import rename_alloc_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic             dec_rd_en,
    input  logic [4:0]       dec_rd,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic [63:0]      dec_payload,
    input  logic [RB*32-1:0] rnAct_X_qout,
    input  logic [RP*32-1:0] rnBufU_qout,
    input  logic [RP*32-1:0] wbLog_qout,
    output logic [RB*32-1:0] rnAct_X_dnxt,
    output logic [RP*32-1:0] rnBufU_rename_set,
    output logic             iss_valid,
    input  logic             iss_ready,
    output logic [TW-1:0]    iss_rd_tag,
    output logic [TW-1:0]    iss_rs1_tag,
    output logic [TW-1:0]    iss_rs2_tag,
    output logic             iss_rs1_rdy,
    output logic             iss_rs2_rdy,
    output logic             iss_rd_en,
    output logic [63:0]      iss_payload,
    output logic [31:0]      stall_cnt
);
    logic          out_free;
    logic          need_slot;
    logic          any_free;
    logic [RB-1:0] free_idx;
    logic          fire;
    logic          alloc;
    logic          pool_stall;
    logic [RP-1:0] rd_used;
    logic [RB-1:0] rs1_act;
    logic [RB-1:0] rs2_act;
    logic [RP-1:0] rs1_wb;
    logic [RP-1:0] rs2_wb;
    logic          rs1_rdy;
    logic          rs2_rdy;

    assign rd_used = rnBufU_qout[dec_rd*RP +: RP];

    rn_free_pick u_pick (
        .used     (rd_used),
        .any_free (any_free),
        .idx      (free_idx)
    );

    assign out_free  = ~iss_valid | iss_ready;
    assign need_slot = dec_rd_en & (dec_rd != 5'd0);
    assign dec_ready = out_free & ~flush & (~need_slot | any_free);
    assign fire      = dec_valid & dec_ready;
    assign alloc     = fire & need_slot;
    assign pool_stall = need_slot & ~any_free & dec_valid
                      & out_free & ~flush;

    // Sources read the pre-allocation pointers, so rs==rd sees the old tag.
    assign rs1_act = rnAct_X_qout[dec_rs1*RB +: RB];
    assign rs2_act = rnAct_X_qout[dec_rs2*RB +: RB];
    assign rs1_wb  = wbLog_qout[dec_rs1*RP +: RP];
    assign rs2_wb  = wbLog_qout[dec_rs2*RP +: RP];
    assign rs1_rdy = (dec_rs1 == 5'd0) | rs1_wb[rs1_act];
    assign rs2_rdy = (dec_rs2 == 5'd0) | rs2_wb[rs2_act];

    always_comb begin
        rnAct_X_dnxt      = rnAct_X_qout;
        rnBufU_rename_set = '0;
        if (alloc) begin
            rnAct_X_dnxt[dec_rd*RB +: RB]      = free_idx;
            rnBufU_rename_set[dec_rd*RP +: RP] = RP'(1) << free_idx;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            iss_valid   <= 1'b0;
            iss_rd_tag  <= '0;
            iss_rs1_tag <= '0;
            iss_rs2_tag <= '0;
            iss_rs1_rdy <= 1'b0;
            iss_rs2_rdy <= 1'b0;
            iss_rd_en   <= 1'b0;
            iss_payload <= '0;
            stall_cnt   <= '0;
        end else begin
            if (flush) begin
                iss_valid <= 1'b0;
            end else if (fire) begin
                iss_valid   <= 1'b1;
                iss_rd_tag  <= need_slot ? {dec_rd, free_idx} : '0;
                iss_rs1_tag <= {dec_rs1, rs1_act};
                iss_rs2_tag <= {dec_rs2, rs2_act};
                iss_rs1_rdy <= rs1_rdy;
                iss_rs2_rdy <= rs2_rdy;
                iss_rd_en   <= need_slot;
                iss_payload <= dec_payload;
            end else if (out_free) begin
                iss_valid <= 1'b0;
            end
            if (pool_stall && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
endmodule
